round_key_ctrl: RTL and testbench
=================================

ROUND_KEY_CTRL -- requirements
Module: round_key_ctrl

Interface
REQ-001 Parameter ROUNDS, default 10, round count driven to the key expander (10/12/14).
REQ-002 Parameter TIMEOUT_CYCLES, default 32, expansion watchdog limit in cycles, legal range 16-255.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 key_valid  input  1  new cipher key offered.
REQ-006 key_in  input  128  cipher key.
REQ-007 key_ready  output  1  key accepted when key_valid && key_ready.
REQ-008 exp_en  output  1  one-cycle start pulse to key expander.
REQ-009 exp_key  output  128  key presented to expander.
REQ-010 exp_rounds_total  output  4  constant ROUNDS.
REQ-011 exp_done  input  1  expander completion pulse; last round key written.
REQ-012 blk_valid  input  1  cipher engine requests one block.
REQ-013 blk_ready  output  1  block accepted when blk_valid && blk_ready.
REQ-014 cipher_start  output  1  one-cycle pulse granting round-key RAM to cipher.
REQ-015 cipher_done  input  1  cipher finished block, releases RAM.
REQ-016 keys_valid  output  1  round-key RAM holds complete schedule.
REQ-017 key_gen  output  8  count of completed expansions.
REQ-018 err  output  1  sticky expansion-timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, EXPAND, READY, CIPHER.
REQ-020 key_ready SHALL be 1 in IDLE and READY only, 0 in EXPAND and CIPHER.
REQ-021 Key handshake SHALL capture key_in into exp_key and enter EXPAND next cycle; exp_en=1 for exactly that first EXPAND cycle.
REQ-022 exp_key SHALL hold stable from capture until the next key handshake.
REQ-023 In EXPAND, exp_done SHALL move to READY next cycle, set keys_valid=1, increment key_gen (255 wraps to 0).
REQ-024 keys_valid SHALL be 0 in IDLE and EXPAND, 1 in READY and CIPHER; a key handshake in READY drops it on the next cycle.
REQ-025 blk_ready SHALL equal (state==READY) && !key_valid; a simultaneous key offer wins over a block request.
REQ-026 Block handshake SHALL enter CIPHER with cipher_start=1 for exactly the first CIPHER cycle.
REQ-027 In CIPHER, cipher_done SHALL return to READY next cycle; at most one block outstanding.
REQ-028 exp_done outside EXPAND and cipher_done outside CIPHER SHALL be ignored.
REQ-029 exp_done in the same cycle as exp_en SHALL be ignored (no zero-latency completion).

Reset
REQ-030 Reset SHALL force IDLE, exp_en=0, cipher_start=0, keys_valid=0, key_gen=0, err=0, exp_key=0, blk_ready=0, key_ready=0 during the reset cycle.
REQ-031 Reset mid-EXPAND or mid-CIPHER SHALL abandon the operation; late exp_done/cipher_done after reset SHALL be ignored.

Configuration
REQ-032 Macro ROUND_KEY_CTRL_TIMEOUT_EN SHALL compile in the expansion watchdog.
REQ-033 With macro: 8-bit counter cleared on EXPAND entry, increments each EXPAND cycle; reaching TIMEOUT_CYCLES-1 without exp_done SHALL set err=1 (sticky until reset), go to IDLE, keys_valid=0, key_gen unchanged.
REQ-034 Without macro: EXPAND waits indefinitely, no counter logic, err tied to 0.

Verification
REQ-035 Reset, key handshake 0x2b7e1516_28aed2a6_abf71588_09cf4f3c, exp_done 11 cycles after exp_en -> one exp_en pulse, exp_key stable, keys_valid=1, key_gen=1, blk_ready=1.
REQ-036 In READY, blk_valid=1 -> cipher_start one cycle; cipher_done 12 cycles later -> READY, blk_ready=1 next cycle; key_ready=0 throughout CIPHER.
REQ-037 key_valid and blk_valid both high in READY -> key accepted, no cipher_start, keys_valid=0 next cycle, second exp_en pulse.
REQ-038 Stray exp_done in READY and stray cipher_done in IDLE -> no state change, key_gen unchanged.
REQ-039 With ROUND_KEY_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=32, exp_done withheld -> err=1 at cycle 31 of EXPAND, IDLE, key_ready=1; without macro -> remains EXPAND, err=0.
REQ-040 256 back-to-back expansions -> key_gen wraps to 0; reset asserted mid-EXPAND -> IDLE, all outputs at reset values.

Source files
------------

// File: rtl/round_key_ctrl.sv
// round_key_ctrl: sequences cipher-key capture, round-key expansion and
// single-block cipher grants over a shared round-key RAM.
//
// Optional feature: define ROUND_KEY_CTRL_TIMEOUT_EN to build in the
// expansion watchdog; without it EXPAND waits indefinitely and err is 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   key_valid/key_ready cipher-key handshake, key_in payload
//   exp_en, exp_key     start pulse and captured key for the key expander
//   exp_rounds_total    constant ROUNDS for the expander
//   exp_done            expander completion pulse
//   blk_valid/blk_ready block request handshake from the cipher engine
//   cipher_start        one-cycle RAM grant pulse, cipher_done releases it
//   keys_valid          RAM holds a complete schedule
//   key_gen             completed expansion count (wraps)
//   err                 sticky expansion-timeout flag
module round_key_ctrl #(
  parameter int unsigned ROUNDS         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         exp_en,
  output logic [127:0] exp_key,
  output logic [3:0]   exp_rounds_total,
  input  logic         exp_done,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic         cipher_start,
  input  logic         cipher_done,
  output logic         keys_valid,
  output logic [7:0]   key_gen,
  output logic         err
);

  localparam int unsigned KEY_W = 128;
  localparam int unsigned GEN_W = 8;
  localparam int unsigned RND_W = 4;

  // Elaboration-time parameter legality
  if (ROUNDS != 10 && ROUNDS != 12 && ROUNDS != 14) begin : g_bad_rounds
    $error("round_key_ctrl: ROUNDS must be 10, 12 or 14");
  end
  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("round_key_ctrl: TIMEOUT_CYCLES must be 16..255");
  end

  typedef enum logic [1:0] {IDLE, EXPAND, READY, CIPHER} state_t;

  state_t             state, state_d;
  logic               exp_en_d, cipher_start_d, keys_valid_d;
  logic [KEY_W-1:0]   exp_key_d;
  logic [GEN_W-1:0]   key_gen_d;
  logic               key_hs, blk_hs, timeout_c;

  // Handshake readiness decodes from state; gated so reset forces them low
  // within the reset cycle itself.
  assign key_ready = !reset && (state == IDLE || state == READY);
  assign blk_ready = !reset && (state == READY) && !key_valid;
  assign key_hs    = key_valid && key_ready;
  assign blk_hs    = blk_valid && blk_ready;

  assign exp_rounds_total = RND_W'(ROUNDS);

`ifdef ROUND_KEY_CTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  // Watchdog: cleared on EXPAND entry, counts every EXPAND cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (key_hs)                to_cnt <= '0;
      else if (state == EXPAND)  to_cnt <= to_cnt + CNT_W'(1);
      if (timeout_c)             err_q  <= 1'b1;
    end
  end

  // exp_done in the final watchdog cycle still wins over the timeout
  assign timeout_c = (state == EXPAND) && !(exp_done && !exp_en) &&
                     (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err       = err_q;
`else
  assign timeout_c = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d        = state;
    exp_en_d       = 1'b0;
    cipher_start_d = 1'b0;
    keys_valid_d   = keys_valid;
    exp_key_d      = exp_key;
    key_gen_d      = key_gen;
    case (state)
      IDLE, READY: begin
        // A key offer takes priority over a block request
        if (key_hs) begin
          state_d      = EXPAND;
          exp_en_d     = 1'b1;
          exp_key_d    = key_in;
          keys_valid_d = 1'b0;
        end else if (blk_hs) begin
          state_d        = CIPHER;
          cipher_start_d = 1'b1;
        end
      end
      EXPAND: begin
        // Completion coinciding with the start pulse is not a real completion
        if (exp_done && !exp_en) begin
          state_d      = READY;
          keys_valid_d = 1'b1;
          key_gen_d    = key_gen + GEN_W'(1);
        end else if (timeout_c) begin
          state_d      = IDLE;
          keys_valid_d = 1'b0;
        end
      end
      CIPHER: begin
        if (cipher_done) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      exp_en       <= 1'b0;
      cipher_start <= 1'b0;
      keys_valid   <= 1'b0;
      exp_key      <= '0;
      key_gen      <= '0;
    end else begin
      state        <= state_d;
      exp_en       <= exp_en_d;
      cipher_start <= cipher_start_d;
      keys_valid   <= keys_valid_d;
      exp_key      <= exp_key_d;
      key_gen      <= key_gen_d;
    end
  end

endmodule

// File: tb/tb_round_key_ctrl.sv
// Self-checking bench for round_key_ctrl (scoreboard of expected keys,
// key_gen values and cipher grants).
module tb_round_key_ctrl;

  logic         clk = 1'b0;
  logic         reset, key_valid, exp_done, blk_valid, cipher_done;
  logic [127:0] key_in;
  logic         key_ready, exp_en, blk_ready, cipher_start, keys_valid, err;
  logic [127:0] exp_key;
  logic [3:0]   exp_rounds_total;
  logic [7:0]   key_gen;

  int total = 0;
  int bad   = 0;
  logic [7:0]   gen_model = 8'd0;
  logic [127:0] key_q[$];
  logic [7:0]   gen_q[$];
  logic         start_q[$];

  localparam logic [127:0] K0 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  round_key_ctrl #(.ROUNDS(10), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .exp_en(exp_en), .exp_key(exp_key),
    .exp_rounds_total(exp_rounds_total), .exp_done(exp_done),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .cipher_start(cipher_start),
    .cipher_done(cipher_done), .keys_valid(keys_valid), .key_gen(key_gen),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key handshake (optionally with a competing block request), exp_done
  // driven lat cycles after the exp_en cycle.
  task automatic expand(input logic [127:0] k, input int lat, input logic with_blk);
    logic [127:0] ek;
    logic [7:0]   eg;
    key_valid = 1'b1; key_in = k; blk_valid = with_blk;
    #1;
    total++;
    if ({key_ready, blk_ready} !== 2'b10) begin
      bad++; $display("FAIL hs_ready got=%b want=10", {key_ready, blk_ready});
    end
    key_q.push_back(k);
    gen_q.push_back(8'(gen_model + 8'd1));
    tick();
    key_valid = 1'b0; blk_valid = 1'b0; key_in = ~k;
    total++;
    if ({exp_en, cipher_start, keys_valid, key_ready} !== 4'b1000) begin
      bad++; $display("FAIL exp_start got=%b want=1000", {exp_en, cipher_start, keys_valid, key_ready});
    end
    total++;
    if (key_q.size() == 0) begin
      bad++; $display("FAIL key_q empty got=0 want=1");
    end else begin
      ek = key_q.pop_front();
      if (exp_key !== ek) begin
        bad++; $display("FAIL exp_key got=%h want=%h", exp_key, ek);
      end
    end
    for (int i = 1; i <= lat; i++) begin
      tick();
      total++;
      if ({exp_en, key_ready, keys_valid} !== 3'b000 || exp_key !== k) begin
        bad++; $display("FAIL expand_hold got=%b/%h want=000/%h", {exp_en, key_ready, keys_valid}, exp_key, k);
      end
    end
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    eg = gen_q.pop_front();
    gen_model = eg;
    total++;
    if ({keys_valid, key_ready, blk_ready} !== 3'b111 || key_gen !== eg) begin
      bad++; $display("FAIL expand_done got=%b/%0d want=111/%0d", {keys_valid, key_ready, blk_ready}, key_gen, eg);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b0; key_in = '0; exp_done = 1'b0;
    blk_valid = 1'b0; cipher_done = 1'b0;
    tick(); tick();
    gen_model = 8'd0;
    total++;
    if ({key_ready, blk_ready, exp_en, cipher_start, keys_valid, err} !== 6'b0 ||
        key_gen !== 8'd0 || exp_key !== 128'd0) begin
      bad++; $display("FAIL reset_vals got=%b/%0d/%h want=000000/0/0",
        {key_ready, blk_ready, exp_en, cipher_start, keys_valid, err}, key_gen, exp_key);
    end
    reset = 1'b0;
    tick();
    total++;
    if ({key_ready, blk_ready, keys_valid} !== 3'b100 || exp_rounds_total !== 4'd10) begin
      bad++; $display("FAIL idle got=%b/%0d want=100/10", {key_ready, blk_ready, keys_valid}, exp_rounds_total);
    end
  endtask

  task automatic test_expand();
    expand(K0, 11, 1'b0);
  endtask

  task automatic test_cipher(input int lat);
    blk_valid = 1'b1;
    #1;
    total++;
    if (blk_ready !== 1'b1) begin
      bad++; $display("FAIL blk_ready got=%b want=1", blk_ready);
    end
    start_q.push_back(1'b1);
    tick();
    total++;
    if (start_q.size() == 0 || cipher_start !== start_q.pop_front() || {key_ready, keys_valid} !== 2'b01) begin
      bad++; $display("FAIL cipher_start got=%b want=101", {cipher_start, key_ready, keys_valid});
    end
    // A second request while busy must not be granted
    for (int i = 1; i <= lat; i++) begin
      blk_valid = (i < lat);
      tick();
      total++;
      if ({cipher_start, key_ready, blk_ready} !== 3'b000) begin
        bad++; $display("FAIL cipher_busy got=%b want=000", {cipher_start, key_ready, blk_ready});
      end
    end
    blk_valid = 1'b0;
    cipher_done = 1'b1;
    tick();
    cipher_done = 1'b0;
    total++;
    if ({blk_ready, key_ready, keys_valid, cipher_start} !== 4'b1110) begin
      bad++; $display("FAIL cipher_done got=%b want=1110", {blk_ready, key_ready, keys_valid, cipher_start});
    end
  endtask

  task automatic test_collision();
    expand(128'h00112233_44556677_8899aabb_ccddeeff, 3, 1'b1);
  endtask

  task automatic test_early_done();
    key_valid = 1'b1; key_in = 128'hfeed;
    tick();
    key_valid = 1'b0;
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    total++;
    if ({key_ready, keys_valid} !== 2'b00 || key_gen !== gen_model) begin
      bad++; $display("FAIL early_done got=%b/%0d want=00/%0d", {key_ready, keys_valid}, key_gen, gen_model);
    end
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    gen_model = 8'(gen_model + 8'd1);
    total++;
    if ({key_ready, keys_valid} !== 2'b11 || key_gen !== gen_model) begin
      bad++; $display("FAIL late_done got=%b/%0d want=11/%0d", {key_ready, keys_valid}, key_gen, gen_model);
    end
  endtask

  task automatic test_stray();
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    total++;
    if ({key_ready, keys_valid, exp_en, blk_ready} !== 4'b1101 || key_gen !== gen_model) begin
      bad++; $display("FAIL stray_exp got=%b/%0d want=1101/%0d", {key_ready, keys_valid, exp_en, blk_ready}, key_gen, gen_model);
    end
    reset = 1'b1; tick(); reset = 1'b0; tick();
    gen_model = 8'd0;
    cipher_done = 1'b1; exp_done = 1'b1;
    tick();
    cipher_done = 1'b0; exp_done = 1'b0;
    total++;
    if ({key_ready, keys_valid, cipher_start, blk_ready} !== 4'b1000 || key_gen !== 8'd0) begin
      bad++; $display("FAIL stray_idle got=%b/%0d want=1000/0", {key_ready, keys_valid, cipher_start, blk_ready}, key_gen);
    end
  endtask

  task automatic test_timeout();
    key_valid = 1'b1; key_in = 128'hdead_beef;
    tick();
    key_valid = 1'b0;
`ifdef ROUND_KEY_CTRL_TIMEOUT_EN
    // EXPAND occupies cycles 0..31; IDLE with err visible afterwards
    for (int i = 1; i <= 31; i++) begin
      tick();
      total++;
      if ({err, key_ready} !== 2'b00) begin
        bad++; $display("FAIL timeout_wait got=%b want=00", {err, key_ready});
      end
    end
    tick();
    total++;
    if ({err, key_ready, keys_valid} !== 3'b110 || key_gen !== gen_model) begin
      bad++; $display("FAIL timeout got=%b/%0d want=110/%0d", {err, key_ready, keys_valid}, key_gen, gen_model);
    end
`else
    for (int i = 1; i <= 40; i++) begin
      tick();
      total++;
      if ({err, key_ready, keys_valid} !== 3'b000) begin
        bad++; $display("FAIL no_timeout got=%b want=000", {err, key_ready, keys_valid});
      end
    end
`endif
    reset = 1'b1; tick(); reset = 1'b0; tick();
    gen_model = 8'd0;
    total++;
    if ({err, key_ready} !== 2'b01) begin
      bad++; $display("FAIL err_clear got=%b want=01", {err, key_ready});
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 256; n++) begin
      expand({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
      if (n == 254) begin
        total++;
        if (key_gen !== 8'd255) begin
          bad++; $display("FAIL gen_255 got=%0d want=255", key_gen);
        end
      end
    end
    total++;
    if (key_gen !== 8'd0) begin
      bad++; $display("FAIL gen_wrap got=%0d want=0", key_gen);
    end
  endtask

  task automatic test_reset_mid();
    key_valid = 1'b1; key_in = 128'h1234;
    tick();
    key_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    key_valid = 1'b1;
    #1;
    total++;
    if ({key_ready, blk_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_comb got=%b want=00", {key_ready, blk_ready});
    end
    tick();
    key_valid = 1'b0;
    total++;
    if ({key_ready, blk_ready, exp_en, cipher_start, keys_valid, err} !== 6'b0 ||
        key_gen !== 8'd0 || exp_key !== 128'd0) begin
      bad++; $display("FAIL reset_mid got=%b/%0d/%h want=000000/0/0",
        {key_ready, blk_ready, exp_en, cipher_start, keys_valid, err}, key_gen, exp_key);
    end
    reset = 1'b0;
    gen_model = 8'd0;
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0;
    total++;
    if ({key_ready, keys_valid} !== 2'b10 || key_gen !== 8'd0) begin
      bad++; $display("FAIL late_exp_done got=%b/%0d want=10/0", {key_ready, keys_valid}, key_gen);
    end
    // Abandon a cipher grant
    expand(128'h5555, 2, 1'b0);
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    gen_model = 8'd0;
    cipher_done = 1'b1;
    tick();
    cipher_done = 1'b0;
    total++;
    if ({key_ready, keys_valid, cipher_start, blk_ready} !== 4'b1000 || key_gen !== 8'd0) begin
      bad++; $display("FAIL reset_cipher got=%b/%0d want=1000/0", {key_ready, keys_valid, cipher_start, blk_ready}, key_gen);
    end
  endtask

  initial begin
    test_reset();
    test_expand();
    test_cipher(12);
    test_collision();
    test_early_done();
    test_stray();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
